// File: rtl/poly_taps_sequencer_pkg.sv
// Shared types and constants for the polynomial taps-programming sequencer.
package poly_taps_pkg;

    localparam int C_FP_DWIDTH    = 32;
    localparam int C_FLUSH_CYCLES = 2;

    typedef logic [C_FP_DWIDTH-1:0] float_t;

    typedef enum logic [1:0] {
        SM_IDLE,
        SM_FLUSH,
        SM_SEND,
        SM_WAIT_DONE
    } state_t;

    // One spare code above the last bank so an out-of-range bank can be requested and flagged.
    function automatic int bank_width(input int num_banks);
        return $clog2(num_banks + 1);
    endfunction

endpackage

// File: rtl/poly_taps_sequencer_if.sv
// Taps-programming stream between the sequencer (master) and the polynomial estimator (slave).
interface poly_taps_sequencer_if;
    import poly_taps_pkg::*;

    float_t taps_prog_dout;
    logic   taps_prog_dout_valid;
    logic   taps_prog_dout_ready;
    logic   taps_prog_done;
    logic   est_enable;

    modport master (
        output taps_prog_dout, taps_prog_dout_valid, est_enable,
        input  taps_prog_dout_ready, taps_prog_done
    );

    modport slave (
        input  taps_prog_dout, taps_prog_dout_valid, est_enable,
        output taps_prog_dout_ready, taps_prog_done
    );
endinterface

// File: rtl/poly_taps_bank_ram.sv
// Coefficient storage for all banks: one synchronous write port, one asynchronous read port.
module poly_taps_bank_ram
    import poly_taps_pkg::*;
#(
    parameter int G_DEPTH = 10,
    parameter int G_AW    = 4
) (
    input  logic            clk,
    input  logic            wr_en,
    input  logic [G_AW-1:0] wr_addr,
    input  float_t          wr_data,
    input  logic [G_AW-1:0] rd_addr,
    output float_t          rd_data
);

    float_t mem [G_DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/poly_taps_sequencer.sv
// Re-arms the polynomial estimator and streams one coefficient bank to it, tap[0]..tap[N-1].
// Optional stall timeout enabled by defining POLY_TAPS_TIMEOUT_EN.
module poly_taps_sequencer
    import poly_taps_pkg::*;
#(
    parameter int G_POLY_ORDER     = 5,
    parameter int G_NUM_BANKS      = 2,
    parameter int G_TIMEOUT_CYCLES = 1024
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic                                coef_wr_en,
    input  logic [bank_width(G_NUM_BANKS)-1:0]  coef_wr_bank,
    input  logic [7:0]                          coef_wr_addr,
    input  float_t                              coef_wr_data,
    output logic                                coef_wr_rejected,
    input  logic                                load_req,
    input  logic [bank_width(G_NUM_BANKS)-1:0]  load_bank,
    output logic                                busy,
    output logic                                load_done,
    output logic                                load_err,
    poly_taps_sequencer_if.master               taps
);

    localparam int C_BW    = bank_width(G_NUM_BANKS);
    localparam int C_DEPTH = G_NUM_BANKS * G_POLY_ORDER;
    localparam int C_AW    = (C_DEPTH > 1) ? $clog2(C_DEPTH) : 1;
    localparam int C_TW    = (G_POLY_ORDER > 1) ? $clog2(G_POLY_ORDER) : 1;
    localparam int C_FW    = (C_FLUSH_CYCLES > 1) ? $clog2(C_FLUSH_CYCLES) : 1;

    localparam logic [C_BW-1:0] C_NB         = C_BW'(G_NUM_BANKS);
    localparam logic [7:0]      C_NT         = 8'(G_POLY_ORDER);
    localparam logic [C_TW-1:0] C_LAST_TAP   = C_TW'(G_POLY_ORDER - 1);
    localparam logic [C_FW-1:0] C_FLUSH_LAST = C_FW'(C_FLUSH_CYCLES - 1);

    state_t          state, state_d;
    logic [C_BW-1:0] bank_q, bank_d;
    logic [C_TW-1:0] tap_idx, tap_d;
    logic [C_FW-1:0] flush_cnt, flush_d;
    logic            busy_d, en_q, en_d, valid_q, valid_d, done_d, err_d;
    float_t          dout_q, dout_d;
    logic            accept, wr_legal, ram_we;
    logic [C_AW-1:0] wr_addr, rd_addr;
    float_t          rd_data;
    int              rd_tap;

`ifdef POLY_TAPS_TIMEOUT_EN
    localparam int C_TMW = (G_TIMEOUT_CYCLES > 1) ? $clog2(G_TIMEOUT_CYCLES) : 1;
    localparam logic [C_TMW-1:0] C_TMO_LAST = C_TMW'(G_TIMEOUT_CYCLES - 1);
    logic [C_TMW-1:0] tmo_cnt, tmo_d;
    logic             stall;
`endif

    assign accept = valid_q && taps.taps_prog_dout_ready;

    // The bank being streamed is write-protected until the load finishes.
    assign wr_legal = (coef_wr_bank < C_NB) && (coef_wr_addr < C_NT)
                      && !((state != SM_IDLE) && (coef_wr_bank == bank_q));
    assign ram_we   = coef_wr_en && wr_legal;
    assign wr_addr  = C_AW'(int'(coef_wr_bank) * G_POLY_ORDER + int'(coef_wr_addr));

    // Prefetch the word after the one on dout so accepted beats can go back-to-back.
    always_comb begin
        rd_tap = 0;
        if (state == SM_SEND && tap_idx != C_LAST_TAP) begin
            rd_tap = int'(tap_idx) + 1;
        end
    end
    assign rd_addr = C_AW'(int'(bank_q) * G_POLY_ORDER + rd_tap);

    poly_taps_bank_ram #(
        .G_DEPTH (C_DEPTH),
        .G_AW    (C_AW)
    ) u_ram (
        .clk     (clk),
        .wr_en   (ram_we),
        .wr_addr (wr_addr),
        .wr_data (coef_wr_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    always_comb begin
        state_d = state;
        bank_d  = bank_q;
        tap_d   = tap_idx;
        flush_d = flush_cnt;
        busy_d  = busy;
        en_d    = en_q;
        valid_d = valid_q;
        dout_d  = dout_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state)
            SM_IDLE: begin
                if (load_req) begin
                    if (load_bank < C_NB) begin
                        bank_d  = load_bank;
                        busy_d  = 1'b1;
                        en_d    = 1'b0;
                        flush_d = '0;
                        state_d = SM_FLUSH;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            SM_FLUSH: begin
                if (flush_cnt == C_FLUSH_LAST) begin
                    en_d    = 1'b1;
                    tap_d   = '0;
                    valid_d = 1'b1;
                    dout_d  = rd_data;
                    state_d = SM_SEND;
                end else begin
                    flush_d = flush_cnt + 1'b1;
                end
            end
            SM_SEND: begin
                if (accept) begin
                    if (tap_idx == C_LAST_TAP) begin
                        valid_d = 1'b0;
                        state_d = SM_WAIT_DONE;
                    end else begin
                        tap_d  = tap_idx + 1'b1;
                        dout_d = rd_data;
                    end
                end
            end
            SM_WAIT_DONE: begin
                if (taps.taps_prog_done) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = SM_IDLE;
                end
            end
            default: state_d = SM_IDLE;
        endcase

`ifdef POLY_TAPS_TIMEOUT_EN
        stall = (state == SM_SEND && !accept)
                || (state == SM_WAIT_DONE && !taps.taps_prog_done);
        tmo_d = '0;
        if (stall) begin
            if (tmo_cnt == C_TMO_LAST) begin
                err_d   = 1'b1;
                en_d    = 1'b0;
                valid_d = 1'b0;
                busy_d  = 1'b0;
                state_d = SM_IDLE;
            end else begin
                tmo_d = tmo_cnt + 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state            <= SM_IDLE;
            bank_q           <= '0;
            tap_idx          <= '0;
            flush_cnt        <= '0;
            busy             <= 1'b0;
            en_q             <= 1'b0;
            valid_q          <= 1'b0;
            dout_q           <= '0;
            load_done        <= 1'b0;
            load_err         <= 1'b0;
            coef_wr_rejected <= 1'b0;
`ifdef POLY_TAPS_TIMEOUT_EN
            tmo_cnt          <= '0;
`endif
        end else begin
            state            <= state_d;
            bank_q           <= bank_d;
            tap_idx          <= tap_d;
            flush_cnt        <= flush_d;
            busy             <= busy_d;
            en_q             <= en_d;
            valid_q          <= valid_d;
            dout_q           <= dout_d;
            load_done        <= done_d;
            load_err         <= err_d;
            coef_wr_rejected <= coef_wr_en && !wr_legal;
`ifdef POLY_TAPS_TIMEOUT_EN
            tmo_cnt          <= tmo_d;
`endif
        end
    end

    assign taps.taps_prog_dout       = dout_q;
    assign taps.taps_prog_dout_valid = valid_q;
    assign taps.est_enable           = en_q;

endmodule

// File: tb/tb_poly_taps_sequencer.sv
// Scoreboard bench for poly_taps_sequencer: expected tap words are queued at load time, a monitor checks the stream.
`timescale 1ns/1ps
module tb_poly_taps_sequencer;
    import poly_taps_pkg::*;

    localparam int N = 5;
    localparam int B = 2;
    localparam int T = 16;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       coef_wr_en = 1'b0;
    logic [1:0] coef_wr_bank = '0;
    logic [7:0] coef_wr_addr = '0;
    float_t     coef_wr_data = '0;
    logic       coef_wr_rejected;
    logic       load_req = 1'b0;
    logic [1:0] load_bank = '0;
    logic       busy, load_done, load_err;

    poly_taps_sequencer_if taps();

    poly_taps_sequencer #(
        .G_POLY_ORDER     (N),
        .G_NUM_BANKS      (B),
        .G_TIMEOUT_CYCLES (T)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .coef_wr_en       (coef_wr_en),
        .coef_wr_bank     (coef_wr_bank),
        .coef_wr_addr     (coef_wr_addr),
        .coef_wr_data     (coef_wr_data),
        .coef_wr_rejected (coef_wr_rejected),
        .load_req         (load_req),
        .load_bank        (load_bank),
        .busy             (busy),
        .load_done        (load_done),
        .load_err         (load_err),
        .taps             (taps)
    );

    always #5 clk = ~clk;

    int     checks = 0;
    int     errors = 0;
    int     cyc = 0;
    int     beats = 0;
    int     rej_cnt = 0;
    int     done_cnt = 0;
    int     err_cnt = 0;
    int     rdy_mode = 0;
    int     acc_cyc[$];
    float_t exp_q[$];
    float_t model [B][N];

    float_t init0 [N] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000};
    float_t init1 [N] = '{32'h41000000, 32'h41100000, 32'h41200000, 32'h41300000, 32'h41400000};
    float_t neg0  [N] = '{32'hBF800000, 32'hC0000000, 32'hC0400000, 32'hC0800000, 32'hC0A00000};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // 0: ready held high, 1: ready toggles every cycle, 2: ready held low
    initial begin
        taps.taps_prog_dout_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       taps.taps_prog_dout_ready = 1'b1;
                1:       taps.taps_prog_dout_ready = ~taps.taps_prog_dout_ready;
                default: taps.taps_prog_dout_ready = 1'b0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (reset_n) begin
            if (coef_wr_rejected) rej_cnt++;
            if (load_done)        done_cnt++;
            if (load_err)         err_cnt++;
            if (taps.taps_prog_dout_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got %h with no word expected", taps.taps_prog_dout);
                end else begin
                    check("tap_word", taps.taps_prog_dout, exp_q[0]);
                    if (taps.taps_prog_dout_ready) begin
                        void'(exp_q.pop_front());
                        acc_cyc.push_back(cyc);
                        beats++;
                    end
                end
            end
        end
    end

    task automatic wr(input logic [1:0] b, input logic [7:0] a, input float_t d, input bit commit);
        coef_wr_en   = 1'b1;
        coef_wr_bank = b;
        coef_wr_addr = a;
        coef_wr_data = d;
        if (commit) model[int'(b)][int'(a)] = d;
        @(posedge clk);
        #1;
        coef_wr_en = 1'b0;
    endtask

    task automatic load(input logic [1:0] b, input bit legal);
        load_req  = 1'b1;
        load_bank = b;
        if (legal) for (int i = 0; i < N; i++) exp_q.push_back(model[int'(b)][i]);
        @(posedge clk);
        #1;
        load_req = 1'b0;
    endtask

    task automatic finish_load(input string name);
        int i;
        int d0;
        d0 = done_cnt;
        for (i = 0; i < 200 && (exp_q.size() != 0 || taps.taps_prog_dout_valid); i++) begin
            @(posedge clk);
            #1;
        end
        check({name, "_stream_end"}, 32'(i < 200), 32'd1);
        taps.taps_prog_done = 1'b1;
        for (i = 0; i < 20 && done_cnt == d0; i++) begin
            @(posedge clk);
            #1;
        end
        check({name, "_load_done"}, done_cnt - d0, 32'd1);
        check({name, "_busy_clear"}, busy, 1'b0);
        check({name, "_en_kept"}, taps.est_enable, 1'b1);
        taps.taps_prog_done = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, r0, e0, i, n;
        taps.taps_prog_done = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_valid", taps.taps_prog_dout_valid, 1'b0);
        check("rst_dout", taps.taps_prog_dout, 32'h0);
        check("rst_en", taps.est_enable, 1'b0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        for (int k = 0; k < N; k++) wr(2'd0, 8'(k), init0[k], 1'b1);
        for (int k = 0; k < N; k++) wr(2'd1, 8'(k), init1[k], 1'b1);
        r0 = rej_cnt;
        wr(2'd0, 8'd5, 32'hDEADBEEF, 1'b0);
        wr(2'd2, 8'd0, 32'hDEADBEEF, 1'b0);
        @(posedge clk);
        #1;
        check("illegal_wr_rejected", rej_cnt - r0, 32'd2);

        // Test 1: full-rate stream with 3-cycle start latency
        rdy_mode = 0;
        base = beats;
        acc_cyc.delete();
        load(2'd0, 1'b1);
        check("t1_busy", busy, 1'b1);
        check("t1_flush1_en", taps.est_enable, 1'b0);
        check("t1_flush1_valid", taps.taps_prog_dout_valid, 1'b0);
        @(posedge clk);
        #1;
        check("t1_flush2_en", taps.est_enable, 1'b0);
        check("t1_flush2_valid", taps.taps_prog_dout_valid, 1'b0);
        @(posedge clk);
        #1;
        check("t1_first_valid", taps.taps_prog_dout_valid, 1'b1);
        check("t1_en_on", taps.est_enable, 1'b1);
        finish_load("t1");
        check("t1_beats", beats - base, 32'd5);
        if (acc_cyc.size() == N) check("t1_consecutive", acc_cyc[N-1] - acc_cyc[0], 32'd4);
        else check("t1_accept_count", acc_cyc.size(), 32'(N));

        // Test 2: ready toggling
        rdy_mode = 1;
        base = beats;
        load(2'd0, 1'b1);
        finish_load("t2");
        check("t2_beats", beats - base, 32'd5);

        // Test 3: writes during a load, then reload bank1 with a simultaneous write
        r0 = rej_cnt;
        base = beats;
        load(2'd0, 1'b1);
        wr(2'd0, 8'd2, 32'hC0400000, 1'b0);
        wr(2'd1, 8'd2, 32'h41F00000, 1'b1);
        @(posedge clk);
        #1;
        check("t3_rejected", rej_cnt - r0, 32'd1);
        check("t3_busy", busy, 1'b1);
        finish_load("t3a");
        coef_wr_en   = 1'b1;
        coef_wr_bank = 2'd1;
        coef_wr_addr = 8'd4;
        coef_wr_data = 32'h42000000;
        model[1][4]  = 32'h42000000;
        load(2'd1, 1'b1);
        coef_wr_en = 1'b0;
        finish_load("t3b");
        check("t3_beats", beats - base, 32'd10);

        // Test 4: illegal load bank
        e0 = err_cnt;
        load(2'd2, 1'b0);
        check("t4_busy", busy, 1'b0);
        check("t4_en_unchanged", taps.est_enable, 1'b1);
        @(posedge clk);
        #1;
        check("t4_load_err", err_cnt - e0, 32'd1);
        check("t4_busy_after", busy, 1'b0);

        // Test 5: load_req while busy ignored; reset after beat 2
        rdy_mode = 0;
        e0 = err_cnt;
        base = beats;
        load(2'd0, 1'b1);
        load_req  = 1'b1;
        load_bank = 2'd1;
        @(posedge clk);
        #1;
        load_req = 1'b0;
        for (i = 0; i < 50 && beats < base + 2; i++) begin
            @(posedge clk);
            #1;
        end
        check("t5_two_beats", beats - base, 32'd2);
        check("t5_busy_req_no_err", err_cnt - e0, 32'd0);
        reset_n = 1'b0;
        #1;
        check("t5_rst_valid", taps.taps_prog_dout_valid, 1'b0);
        check("t5_rst_dout", taps.taps_prog_dout, 32'h0);
        check("t5_rst_en", taps.est_enable, 1'b0);
        check("t5_rst_busy", busy, 1'b0);
        exp_q.delete();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < N; k++) wr(2'd0, 8'(k), neg0[k], 1'b1);
        base = beats;
        load(2'd0, 1'b1);
        finish_load("t5");
        check("t5_beats", beats - base, 32'd5);

        // Test 6: stalled stream
        rdy_mode = 2;
        e0 = err_cnt;
        load(2'd1, 1'b1);
        for (i = 0; i < 10 && !taps.taps_prog_dout_valid; i++) begin
            @(posedge clk);
            #1;
        end
        check("t6_valid_seen", taps.taps_prog_dout_valid, 1'b1);
`ifdef POLY_TAPS_TIMEOUT_EN
        n = 0;
        while (n < 100 && !load_err) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("t6_timeout_cycle", n, 32'(T));
        check("t6_en_off", taps.est_enable, 1'b0);
        check("t6_busy_off", busy, 1'b0);
        check("t6_valid_off", taps.taps_prog_dout_valid, 1'b0);
        exp_q.delete();
        rdy_mode = 0;
`else
        n = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("t6_no_timeout_err", err_cnt - e0, 32'd0);
        check("t6_still_valid", taps.taps_prog_dout_valid, 1'b1);
        check("t6_still_busy", busy, 1'b1);
        rdy_mode = 0;
        finish_load("t6");
`endif

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
